led_matrix_scan: RTL and testbench

Double-buffered 8×8 LED matrix scan driver that sits downstream of the CPU core and owns the physical `col`/`row` pins. The CPU writes row bytes into a back buffer and requests a swap. The block swaps buffers only at a frame boundary, so the display never tears. It also inserts a blanking gap between rows to suppress ghosting and applies a 3-bit brightness PWM within each row's dwell time.

---
 rtl/led_matrix_scan.sv | 141 ++++++++++++++
 tb/tb_led_matrix_scan.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan.sv
// Double-buffered 8x8 LED matrix scan driver: row dwell with brightness PWM,
// inter-row blanking, and tear-free front/back buffer swap at frame end.
module led_matrix_scan #(
    parameter int unsigned DWELL = 8192,
    parameter int unsigned BLANK = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       swap_req,
    input  logic [2:0] brightness,
    output logic [7:0] col,
    output logic [7:0] row,
    output logic       swap_pending,
    output logic       frame_tick
);
    localparam int unsigned OT_W  = $clog2(DWELL) + 4;
    localparam int unsigned MAXC  = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned CNT_W = $clog2(MAXC) + 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_BLANK  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_row_idx;
    logic [2:0]       w_row_idx_nxt;
    logic [2:0]       r_bright;
    logic [2:0]       w_bright_nxt;
    logic             r_started;
    logic             r_sel;
    logic [7:0]       r_buf [0:1][0:7];
    logic [7:0]       r_col;
    logic [7:0]       r_row;
    logic             r_tick;
    logic             r_pending;
    logic [OT_W-1:0]  w_on_time;
    logic             w_lit;
    logic             w_frame_end;
    logic [7:0]       w_row_nxt;
    logic [7:0]       w_col_nxt;

    assign col          = r_col;
    assign row          = r_row;
    assign swap_pending = r_pending;
    assign frame_tick   = r_tick;

    // Slot sequencing, PWM gating and next pin values from the current position
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + CNT_W'(1);
        w_row_idx_nxt = r_row_idx;
        w_bright_nxt  = r_bright;
        w_frame_end   = 1'b0;
        w_row_nxt     = 8'hFF;
        w_col_nxt     = 8'h00;
        w_on_time     = OT_W'(((OT_W'(r_bright) + OT_W'(1)) * OT_W'(DWELL)) >> 3);
        w_lit         = (r_state == ST_ACTIVE) && (OT_W'(r_cnt) < w_on_time);

        case (r_state)
            ST_ACTIVE: begin
                if (r_cnt == DWELL_LAST) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                end
            end
            ST_BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_state_nxt   = ST_ACTIVE;
                    w_cnt_nxt     = '0;
                    w_row_idx_nxt = r_row_idx + 3'd1;
                    w_bright_nxt  = brightness;
                    w_frame_end   = (r_row_idx == 3'd7);
                end
            end
            default: ;
        endcase

        if (w_lit) begin
            w_row_nxt = ~(8'h01 << r_row_idx);
            w_col_nxt = r_buf[r_sel][r_row_idx];
        end
    end

    // The first edge out of reset only arms the scan, giving one cycle of pin latency
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_ACTIVE;
            r_cnt     <= '0;
            r_row_idx <= 3'd0;
            r_bright  <= 3'd7;
            r_started <= 1'b0;
            r_sel     <= 1'b0;
            r_pending <= 1'b0;
            r_row     <= 8'hFF;
            r_col     <= 8'h00;
            r_tick    <= 1'b0;
        end else begin
            r_started <= 1'b1;
            if (r_started) begin
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_row_idx <= w_row_idx_nxt;
                r_bright  <= w_bright_nxt;
                r_row     <= w_row_nxt;
                r_col     <= w_col_nxt;
                r_tick    <= w_frame_end;
            end
            if (r_started && w_frame_end) begin
                if (r_pending || swap_req) begin
                    r_sel <= ~r_sel;
                end
                r_pending <= 1'b0;
            end else if (swap_req) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Writes target the pre-swap back buffer, even on the swap edge itself
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 8; i++) begin
                    r_buf[b][i] <= 8'h00;
                end
            end
        end else if (wr_en) begin
            r_buf[~r_sel][wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: cycle-count based display model checked every cycle,
// plus literal pin expectations at hand-picked edges.
module tb_led_matrix_scan;
    localparam int unsigned DWELL = 16;
    localparam int unsigned BLANK = 4;
    localparam int SLOT  = 20;
    localparam int FRAME = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'h00;
    logic       swap_req = 1'b0;
    logic [2:0] brightness = 3'd7;
    logic [7:0] col;
    logic [7:0] row;
    logic       swap_pending;
    logic       frame_tick;

    led_matrix_scan #(.DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .brightness  (brightness),
        .col         (col),
        .row         (row),
        .swap_pending(swap_pending),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    logic [7:0] m_front [8];
    logic [7:0] m_back  [8];
    bit         m_pend;
    int         m_bright;
    int         edge_no = 0;
    bit         m_valid = 1'b0;
    logic [7:0] e_row;
    logic [7:0] e_col;
    logic       e_tick;
    logic       e_pend;
    int         n_checks = 0;
    int         n_pass = 0;

    function automatic int on_time(input int b);
        return ((b + 1) * int'(DWELL)) / 8;
    endfunction

    // Model: edge n shows slot position n-1 of a free-running scan counted from release
    always @(posedge clk) begin : model
        int   pos;
        int   slot;
        int   r;
        logic [7:0] tmp;
        m_valid = 1'b1;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_front[i] = 8'h00;
                m_back[i]  = 8'h00;
            end
            m_pend   = 1'b0;
            m_bright = 7;
            e_row    = 8'hFF;
            e_col    = 8'h00;
            e_tick   = 1'b0;
            e_pend   = 1'b0;
            edge_no  = 0;
        end else begin
            e_row  = 8'hFF;
            e_col  = 8'h00;
            e_tick = 1'b0;
            if (edge_no >= 1) begin
                pos  = edge_no - 1;
                slot = pos % SLOT;
                r    = (pos / SLOT) % 8;
                if (slot < on_time(m_bright)) begin
                    tmp   = 8'h01 << r;
                    e_row = ~tmp;
                    e_col = m_front[r];
                end
                e_tick = ((pos % FRAME) == FRAME - 1);
            end
            if (edge_no > 0 && (edge_no % SLOT) == 0) m_bright = int'(brightness);
            if (wr_en) m_back[wr_addr] = wr_data;
            if (e_tick) begin
                if (m_pend || swap_req) begin
                    for (int i = 0; i < 8; i++) begin
                        tmp = m_front[i];
                        m_front[i] = m_back[i];
                        m_back[i]  = tmp;
                    end
                end
                m_pend = 1'b0;
            end else if (swap_req) begin
                m_pend = 1'b1;
            end
            e_pend  = m_pend;
            edge_no = edge_no + 1;
        end
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s after edge %0d: got %h, want %h", name, edge_no - 1, act, exp_v);
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check8("row", row, e_row);
            check8("col", col, e_col);
            check8("frame_tick", {7'd0, frame_tick}, {7'd0, e_tick});
            check8("swap_pending", {7'd0, swap_pending}, {7'd0, e_pend});
        end
    end

    // Returns at the falling edge just before rising edge k
    task automatic goto(input int k);
        int guard = 0;
        while (edge_no != k && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        if (edge_no != k) begin
            n_checks++;
            $display("FAIL goto edge %0d: stuck at %0d, want %0d", k, edge_no, k);
        end
    endtask

    task automatic pulse_swap(input int k);
        goto(k);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
    endtask

    task automatic write_at(input int k, input logic [2:0] a, input logic [7:0] d);
        goto(k);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic expect_pins(input int k, input string tag, input logic [7:0] r_exp,
                               input logic [7:0] c_exp);
        goto(k + 1);
        check8({tag, "_row"}, row, r_exp);
        check8({tag, "_col"}, col, c_exp);
    endtask

    task automatic expect_flags(input int k, input string tag, input logic t_exp,
                                input logic p_exp);
        goto(k + 1);
        check8({tag, "_tick"}, {7'd0, frame_tick}, {7'd0, t_exp});
        check8({tag, "_pend"}, {7'd0, swap_pending}, {7'd0, p_exp});
    endtask

    initial begin
        logic [7:0] d;
        repeat (3) @(negedge clk);
        check8("rst_row", row, 8'hFF);
        check8("rst_col", col, 8'h00);
        check8("rst_flags", {6'd0, frame_tick, swap_pending}, 8'h00);
        rst = 1'b0;

        // Frame 1: empty front, load back, request swap
        expect_pins(1, "f1_r0", 8'hFE, 8'h00);
        for (int i = 0; i < 8; i++) begin
            d = 8'h01 << i;
            write_at(2 + i, 3'(i), d);
        end
        pulse_swap(30);
        expect_flags(31, "f1_req", 1'b0, 1'b1);
        expect_flags(159, "f1_pre", 1'b0, 1'b1);
        expect_flags(160, "f1_end", 1'b1, 1'b0);

        // Frame 2: swapped pattern, brightness changes apply from the next row
        expect_pins(161, "f2_r0", 8'hFE, 8'h01);
        goto(170);
        brightness = 3'd0;
        expect_pins(177, "f2_r0_dark", 8'hFF, 8'h00);
        expect_pins(181, "f2_r1", 8'hFD, 8'h02);
        expect_pins(182, "f2_r1_b0", 8'hFD, 8'h02);
        expect_pins(183, "f2_r1_dark", 8'hFF, 8'h00);
        goto(230);
        brightness = 3'd3;
        expect_pins(248, "f2_r4", 8'hEF, 8'h10);
        expect_pins(249, "f2_r4_dark", 8'hFF, 8'h00);

        // Write and swap request together on the frame-end cycle
        goto(320);
        wr_en    = 1'b1;
        wr_addr  = 3'd5;
        wr_data  = 8'hAA;
        swap_req = 1'b1;
        @(negedge clk);
        wr_en    = 1'b0;
        swap_req = 1'b0;
        check8("co_tick", {7'd0, frame_tick}, 8'h01);
        check8("co_pend", {7'd0, swap_pending}, 8'h00);
        expect_pins(321, "f3_r0", 8'hFE, 8'h00);

        // Three requests in one frame give exactly one swap
        pulse_swap(340);
        pulse_swap(350);
        pulse_swap(360);
        expect_flags(361, "f3_req", 1'b0, 1'b1);
        expect_pins(421, "f3_r5", 8'hDF, 8'hAA);
        expect_flags(480, "f3_end", 1'b1, 1'b0);
        expect_pins(481, "f4_r0", 8'hFE, 8'h01);
        expect_flags(640, "f4_end", 1'b1, 1'b0);
        expect_pins(641, "f5_r0", 8'hFE, 8'h01);

        // Reset while row 3 is lit and a swap is pending
        pulse_swap(650);
        goto(695);
        brightness = 3'd7;
        expect_pins(715, "f5_r3", 8'hF7, 8'h08);
        check8("f5_r3_pend", {7'd0, swap_pending}, 8'h01);
        goto(716);
        rst = 1'b1;
        @(negedge clk);
        check8("mid_rst_row", row, 8'hFF);
        check8("mid_rst_col", col, 8'h00);
        check8("mid_rst_pend", {7'd0, swap_pending}, 8'h00);
        rst = 1'b0;

        // Restart from row 0; both buffers are empty after a swap
        expect_pins(1, "rs_r0", 8'hFE, 8'h00);
        pulse_swap(10);
        expect_flags(160, "rs_end", 1'b1, 1'b0);
        expect_pins(161, "rs_f2_r0", 8'hFE, 8'h00);
        expect_pins(181, "rs_f2_r1", 8'hFD, 8'h00);
        goto(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
